// File: rtl/stoch_div_array.sv
// stoch_div_array: multi-channel stochastic divider, y ~= a/b per channel via a
// clamped counter-feedback loop, all channels thresholded from one shared LFSR.
module fibonacci_lfsr #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [WIDTH-1:0] o_r
);
    localparam logic [63:0] SEED = 64'h9E37_79B9_7F4A_7C15;
    logic w_fb;
    if (WIDTH == 20) begin : g_t20
        assign w_fb = o_r[19] ^ o_r[16];
    end else begin : g_t64
        assign w_fb = o_r[63] ^ o_r[62] ^ o_r[60] ^ o_r[59];
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) o_r <= SEED[WIDTH-1:0];
        else          o_r <= {o_r[WIDTH-2:0], w_fb};
endmodule

module stoch_div_array #(
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 10,
    parameter int CMP_BITS      = 6,
    parameter int LFSR_WIDTH    = 64,
    parameter int SAT_MIN       = -100,
    parameter int SAT_MAX       = (1 << (COUNTER_WIDTH - 1)) - 1
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [CHANNELS-1:0]               en,
    input  logic [CHANNELS-1:0]               clr,
    input  logic [CHANNELS-1:0]               a,
    input  logic [CHANNELS-1:0]               b,
    output logic [CHANNELS-1:0]               y,
    output logic [CHANNELS*COUNTER_WIDTH-1:0] count,
    output logic [CHANNELS-1:0]               sat_hi,
    output logic [CHANNELS-1:0]               sat_lo
);
    localparam int W = COUNTER_WIDTH;
    localparam int L = (LFSR_WIDTH == 20) ? 20 : 64;
    localparam logic signed [W+1:0] NEW_MAX = (W+2)'(SAT_MAX);
    localparam logic signed [W+1:0] NEW_MIN = (W+2)'(SAT_MIN);
    localparam logic signed [W-1:0] CNT_MAX = W'(SAT_MAX);
    localparam logic signed [W-1:0] CNT_MIN = W'(SAT_MIN);

    logic [L-1:0] w_lfsr;

    fibonacci_lfsr #(.WIDTH(L)) u_lfsr (
        .i_clk  (CLK),
        .i_rst_n(nRST),
        .o_r    (w_lfsr)
    );

    // Threshold bits wrap around the LFSR one bit at a time.
    function automatic logic [CMP_BITS-1:0] f_slice(input logic [L-1:0] r, input int base);
        logic [CMP_BITS-1:0] s;
        for (int j = 0; j < CMP_BITS; j++) s[j] = r[(base + j) % L];
        return s;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic signed [W-1:0] r_cnt, w_next;
        logic signed [W+1:0] w_new;
        logic [CMP_BITS-1:0] w_thr;
        logic r_fb, r_hi, r_lo, w_hi, w_lo, w_gt;
        assign w_new  = {{2{r_cnt[W-1]}}, r_cnt} + {{W{1'b0}}, a[i], 1'b0} - {{W{1'b0}}, r_fb, 1'b0};
        assign w_hi   = w_new > NEW_MAX;
        assign w_lo   = w_new < NEW_MIN;
        assign w_next = w_hi ? CNT_MAX : w_lo ? CNT_MIN : w_new[W-1:0];
        assign w_thr  = f_slice(w_lfsr, i * CMP_BITS);
        assign w_gt   = w_next > $signed({{(W-CMP_BITS){1'b0}}, w_thr});
        // Reset gates y directly so it drops with nRST, not on the next edge.
        assign y[i]   = nRST & en[i] & ~clr[i] & w_gt;
        always_ff @(posedge CLK or negedge nRST)
            if (!nRST) begin
                r_cnt <= '0;
                r_fb  <= 1'b0;
                r_hi  <= 1'b0;
                r_lo  <= 1'b0;
            end else if (clr[i]) begin
                r_cnt <= '0;
                r_fb  <= 1'b0;
                r_hi  <= 1'b0;
                r_lo  <= 1'b0;
            end else if (en[i]) begin
                r_cnt <= w_next;
                r_fb  <= y[i] & b[i];
                r_hi  <= r_hi | w_hi;
                r_lo  <= r_lo | w_lo;
            end
        assign count[i*W +: W] = r_cnt;
        assign sat_hi[i]       = r_hi;
        assign sat_lo[i]       = r_lo;
    end
endmodule

// File: tb/tb_stoch_div_array.sv
// tb_stoch_div_array: directed checks of reset, ramp/clamp, enable/clear and lower
// clamp, plus density checks of the divide function on 4- and 12-channel arrays.
module tb_stoch_div_array;
    localparam int N = 16384;
    localparam int TOL = 491;

    logic CLK = 1'b0, nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic [3:0]   en0 = '0, clr0 = '0, a0 = '0, b0 = '0, y0, hi0, lo0;
    logic [39:0]  cnt0;
    logic         en1 = 1'b0, clr1 = 1'b0, a1 = 1'b0, b1 = 1'b0, y1, hi1, lo1;
    logic [7:0]   cnt1;
    logic [11:0]  en2 = '0, clr2 = '0, a2 = '0, b2 = '0, y2, hi2, lo2;
    logic [119:0] cnt2;

    int checks = 0, errors = 0;
    int ny0[4];
    int ny2[12];

    stoch_div_array u0 (
        .CLK(CLK), .nRST(nRST), .en(en0), .clr(clr0), .a(a0), .b(b0),
        .y(y0), .count(cnt0), .sat_hi(hi0), .sat_lo(lo0)
    );

    stoch_div_array #(.CHANNELS(1), .COUNTER_WIDTH(8), .CMP_BITS(1), .SAT_MIN(-4)) u1 (
        .CLK(CLK), .nRST(nRST), .en(en1), .clr(clr1), .a(a1), .b(b1),
        .y(y1), .count(cnt1), .sat_hi(hi1), .sat_lo(lo1)
    );

    stoch_div_array #(.CHANNELS(12)) u2 (
        .CLK(CLK), .nRST(nRST), .en(en2), .clr(clr2), .a(a2), .b(b2),
        .y(y2), .count(cnt2), .sat_hi(hi2), .sat_lo(lo2)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic signed [31:0] c0(input int ch);
        return 32'($signed(cnt0[ch*10 +: 10]));
    endfunction

    function automatic logic signed [31:0] c1();
        return 32'($signed(cnt1));
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset state, with inputs that would otherwise drive y high
        en0 = 4'hF; a0 = 4'hF; en1 = 1'b1; a1 = 1'b1; en2 = 12'hFFF; a2 = 12'hFFF;
        #3;
        for (int i = 0; i < 4; i++) chk($sformatf("rst_cnt%0d", i), c0(i), 0);
        chk("rst_y0", y0, 0);
        chk("rst_hi0", hi0, 0);
        chk("rst_lo0", lo0, 0);
        chk("rst_y1", y1, 0);
        chk("rst_y2", y2, 0);
        en0 = '0; a0 = '0; en1 = 1'b0; a1 = 1'b0; en2 = '0; a2 = '0;
        tick(1);
        nRST = 1'b1;

        // async reset mid-run
        en0 = 4'h1; a0 = 4'h1; b0 = 4'h0;
        tick(20);
        chk("run20_cnt0", c0(0), 40);
        chk("run20_cnt1_idle", c0(1), 0);
        #2; nRST = 1'b0; #1;
        chk("async_rst_cnt0", c0(0), 0);
        chk("async_rst_y0", y0, 0);
        chk("async_rst_hi0", hi0, 0);
        tick(1); nRST = 1'b1;
        tick(1);
        chk("restart_cnt0", c0(0), 2);

        // ramp to the upper clamp on all channels
        en0 = 4'hF; clr0 = 4'hF; a0 = 4'hF; #1;
        chk("clr_y0", y0, 0);
        tick(1); clr0 = '0; a0 = '0; #1;
        chk("zero_next_y0", y0, 0);
        chk("cleared_cnt0", c0(0), 0);
        a0 = 4'hF;
        for (int k = 1; k <= 255; k++) begin
            tick(1);
            chk($sformatf("ramp%0d", k), c0(0), 2 * k);
            chk($sformatf("ramp_hi%0d", k), hi0, 0);
            if (2 * k + 2 >= 64) chk($sformatf("ramp_y%0d", k), y0, 15);
        end
        tick(1);
        for (int i = 0; i < 4; i++) chk($sformatf("clamp_cnt%0d", i), c0(i), 511);
        chk("clamp_hi0", hi0, 15);
        chk("clamp_lo0", lo0, 0);
        chk("clamp_y0", y0, 15);
        tick(3);
        chk("clamp_hold_cnt2", c0(2), 511);

        // clear one channel, then freeze it with en low
        clr0 = 4'b0010; #1;
        chk("clr1_y0", y0, 4'b1101);
        tick(1); clr0 = '0;
        chk("clr1_cnt1", c0(1), 0);
        chk("clr1_cnt0", c0(0), 511);
        chk("clr1_hi0", hi0, 4'b1101);
        tick(10);
        chk("reramp_cnt1", c0(1), 20);
        en0 = 4'b1101; #1;
        chk("dis_y0", y0, 4'b1101);
        tick(50);
        chk("frozen_cnt1", c0(1), 20);
        chk("frozen_y1", y0[1], 0);
        chk("frozen_hi0", hi0, 4'b1101);
        en0 = 4'hF;
        tick(1);
        chk("resume_cnt1", c0(1), 22);

        // lower clamp instance: feedback cannot push the counter past SAT_MIN
        en1 = 1'b1; a1 = 1'b1; b1 = 1'b1; #1;
        chk("u1_y_first", y1, 1);
        tick(1);
        chk("u1_cnt_a", c1(), 2);
        chk("u1_y_steady", y1, 1);
        tick(1);
        chk("u1_cnt_b", c1(), 2);
        a1 = 1'b0; #1;
        chk("u1_y_drop", y1, 0);
        tick(1);
        chk("u1_cnt_c", c1(), 0);
        tick(5);
        chk("u1_cnt_floor", c1(), 0);
        chk("u1_lo", lo1, 0);
        chk("u1_hi", hi1, 0);
        a1 = 1'b1; b1 = 1'b0;
        tick(63);
        chk("u1_ramp126", c1(), 126);
        chk("u1_hi_pre", hi1, 0);
        tick(1);
        chk("u1_clamp127", c1(), 127);
        chk("u1_hi_set", hi1, 1);
        tick(2);
        chk("u1_hold127", c1(), 127);
        chk("u1_lo_final", lo1, 0);

        // divide densities: 0.25/0.5 -> 0.5 and 0.1/0.8 -> 0.125
        for (int m = 0; m < 2; m++) begin
            en0 = 4'hF; en2 = 12'hFFF; clr0 = 4'hF; clr2 = 12'hFFF; a0 = '0; a2 = '0;
            tick(1);
            clr0 = '0; clr2 = '0;
            for (int i = 0; i < 4; i++) ny0[i] = 0;
            for (int i = 0; i < 12; i++) ny2[i] = 0;
            for (int t = 0; t < N; t++) begin
                a0 = {4{(m == 0) ? (t % 4 == 0) : (t % 10 == 0)}};
                a2 = {12{a0[0]}};
                for (int i = 0; i < 4; i++)
                    b0[i] = (m == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) != 0);
                for (int i = 0; i < 12; i++)
                    b2[i] = (m == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) != 0);
                #1;
                for (int i = 0; i < 4; i++) ny0[i] += int'(y0[i]);
                for (int i = 0; i < 12; i++) ny2[i] += int'(y2[i]);
                tick(1);
            end
            for (int i = 0; i < 4; i++)
                chk_rng($sformatf("dens%0d_u0_ch%0d", m, i), ny0[i],
                        ((m == 0) ? N / 2 : N / 8) - TOL, ((m == 0) ? N / 2 : N / 8) + TOL);
            for (int i = 0; i < 12; i++)
                chk_rng($sformatf("dens%0d_u2_ch%0d", m, i), ny2[i],
                        ((m == 0) ? N / 2 : N / 8) - TOL, ((m == 0) ? N / 2 : N / 8) + TOL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
